sdram_init_monitor: RTL and testbench
=====================================

# sdram_init_monitor

Synthesizable receiving-end checker for the SDRAM power-up command stream. It sits on the `sd_cmd`/`sd_a` bus between the init sequencer and the SDRAM pins. It decodes every command, enforces the precharge-all → load-mode ordering and the tRP/tMRD spacing, and captures the programmed mode register. It raises `init_done` when the device is legally initialised and a sticky error with a code on the first protocol violation.

## Interface
Parameters:
- `T_RP`, default 3: minimum cycles from PRECHARGE to the next non-idle command.
- `T_MRD`, default 2: minimum cycles from LOAD_MODE to the next non-idle command.

Ports:
- `sd_clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `sd_clk`.
- `sd_cmd` in 4: `{cs_n, ras_n, cas_n, we_n}`.
- `sd_a` in 13: multiplexed address bus.
- `init_done` out 1: legal init sequence completed.
- `mode_reg` out 13: last accepted LOAD_MODE address.
- `mode_valid` out 1: `mode_reg` holds a captured value.
- `err` out 1: sticky protocol error.
- `err_code` out 3: code of the first error.
- `lmr_count` out 4: saturating count of LOAD_MODE commands.

## Operation
- Decode: `sd_cmd[3]=1` is INHIBIT. The remaining `{ras_n,cas_n,we_n}` values decode as 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 110 BURST_TERM, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE.
- Idle commands are INHIBIT and NOP. Every other command is non-idle.
- FSM states are WAIT_PRE, WAIT_LMR, WAIT_LMR2, READY and ERROR.
- WAIT_PRE:
  - PRECHARGE with `sd_a[10]=1` goes to WAIT_LMR.
  - PRECHARGE with `sd_a[10]=0` is err 2.
  - Any other non-idle command is err 1 (early command).
- WAIT_LMR:
  - LOAD_MODE loads `mode_reg`, sets `mode_valid` and goes to READY (or to WAIT_LMR2, see Configuration).
  - A further PRECHARGE-all or AUTO_REFRESH is allowed and stays in WAIT_LMR.
  - ACTIVE, READ, WRITE or BURST_TERM is err 1.
- READY:
  - `init_done=1`.
  - All commands are legal.
  - LOAD_MODE updates `mode_reg`.
- Spacing counter:
  - Loads T_RP−1 on PRECHARGE and T_MRD−1 on LOAD_MODE.
  - Decrements to 0 on every other cycle.
  - A non-idle command while the counter is non-zero is err 3 (last command was PRECHARGE) or err 4 (last was LOAD_MODE). This check applies in every state except ERROR.
- Error handling:
  - Any error goes to ERROR and latches `err=1` and `err_code`.
  - ERROR is left only by reset.
  - `mode_reg`, `lmr_count` and `init_done` freeze there.
- Priority in a single cycle: spacing violation beats ordering violation. Only the first error is recorded.
- `lmr_count` increments on every LOAD_MODE, including ones that cause an error, and saturates at 15.

## Timing
- All outputs are registered. The command sampled at edge n is reflected in the outputs after edge n.
- With T_RP=3, a PRECHARGE at cycle n permits a non-idle command at cycle n+3 at the earliest. Cycle n+2 is an error.
- Reset values: `init_done=0`, `mode_reg=0`, `mode_valid=0`, `err=0`, `err_code=0`, `lmr_count=0`, state WAIT_PRE, spacing counter 0.
- Reset asserted mid-sequence or in ERROR returns to reset values on the next edge. The command present in the reset cycle is ignored.
- `init_done` rises in the cycle after the qualifying LOAD_MODE. It falls only on reset or error.

## Configuration
- The macro is `SDRAM_MON_DOUBLE_LMR_EN`.
- Defined:
  - The first LOAD_MODE in WAIT_LMR goes to WAIT_LMR2.
  - `init_done` requires a second LOAD_MODE whose `sd_a` equals `mode_reg`.
  - A mismatching second LOAD_MODE is err 5.
  - In WAIT_LMR2, idle commands and AUTO_REFRESH are legal. Other non-idle commands are err 1.
- Undefined: WAIT_LMR2 and err 5 do not exist. The first LOAD_MODE goes directly to READY.

## Test plan
- **Nominal sequence (macro defined).** Reset, then the following stream:
  - PRECHARGE with `sd_a=0x0400`;
  - 175 INHIBIT cycles;
  - LOAD_MODE with `sd_a=0x0022`;
  - 15 INHIBIT cycles;
  - LOAD_MODE with `sd_a=0x0022`.

  Required response: `init_done=1`, `mode_reg=0x0022`, `lmr_count=2`, `err=0`.
- **Early command.** ACTIVE before any PRECHARGE → `err=1`, `err_code=1`, `init_done` stays 0.
- **Single-bank precharge.** PRECHARGE with `sd_a=0x0000` in WAIT_PRE → `err_code=2`.
- **tRP violation (T_RP=3).** PRECHARGE-all at cycle n, LOAD_MODE at cycle n+2 → `err_code=3`, `mode_reg` unchanged at 0.
- **Second-LMR mismatch (macro defined).** LOAD_MODE `0x0022` followed by LOAD_MODE `0x0023` → `err_code=5`, `lmr_count=2`. With the macro undefined, the same stream gives `init_done=1` and `mode_reg=0x0023`.
- **Reset out of ERROR.** Reset asserted in ERROR → all outputs return to their reset values on the next edge, then the nominal sequence passes.

Source files
------------

// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor
//
// Passive checker for the SDRAM power-up command stream. Decodes every command
// on sd_cmd/sd_a, enforces PRECHARGE-all -> LOAD_MODE ordering and the
// tRP/tMRD command spacing, captures the programmed mode register, and flags
// the first protocol violation with a sticky error code.
//
// Optional feature: define SDRAM_MON_DOUBLE_LMR_EN to require a second,
// identical LOAD_MODE before init_done is raised (mismatch is error 5).
//
// Parameters:
//   T_RP   minimum cycles from PRECHARGE to the next non-idle command
//   T_MRD  minimum cycles from LOAD_MODE to the next non-idle command
//
// Ports:
//   sd_clk      clock
//   reset       synchronous, active-high reset
//   sd_cmd      {cs_n, ras_n, cas_n, we_n}
//   sd_a        multiplexed address bus
//   init_done   legal init sequence completed
//   mode_reg    last accepted LOAD_MODE address
//   mode_valid  mode_reg holds a captured value
//   err         sticky protocol error
//   err_code    code of the first error (1 early, 2 single-bank precharge,
//               3 tRP, 4 tMRD, 5 second LOAD_MODE mismatch)
//   lmr_count   saturating count of LOAD_MODE commands

module sdram_init_monitor #(
  parameter int unsigned T_RP  = 3,
  parameter int unsigned T_MRD = 2
) (
  input  logic        sd_clk,
  input  logic        reset,
  input  logic [3:0]  sd_cmd,
  input  logic [12:0] sd_a,
  output logic        init_done,
  output logic [12:0] mode_reg,
  output logic        mode_valid,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [3:0]  lmr_count
);

  localparam int unsigned SpcMax = (T_RP > T_MRD) ? T_RP : T_MRD;
  localparam int unsigned SpcW   = (SpcMax > 2) ? $clog2(SpcMax) : 1;
  localparam logic [SpcW-1:0] TrpLoad = SpcW'(T_RP - 1);
  localparam logic [SpcW-1:0] TmrdLoad = SpcW'(T_MRD - 1);

  typedef enum logic [2:0] {
    StWaitPre,
    StWaitLmr,
    StReady,
    StError
`ifdef SDRAM_MON_DOUBLE_LMR_EN
    , StWaitLmr2
`endif
  } state_e;

  state_e          state_q;
  logic [SpcW-1:0] spc_q;
  logic            last_lmr_q;
  logic            init_done_q;
  logic [12:0]     mode_reg_q;
  logic            mode_valid_q;
  logic            err_q;
  logic [2:0]      err_code_q;
  logic [3:0]      lmr_count_q;

  // Command decode
  logic       cmd_idle, cmd_pre, cmd_lmr, cmd_ref, cmd_data;
  logic [2:0] rcw;

  always_comb begin
    rcw      = sd_cmd[2:0];
    cmd_idle = sd_cmd[3] || (rcw == 3'b111);
    cmd_pre  = !sd_cmd[3] && (rcw == 3'b010);
    cmd_lmr  = !sd_cmd[3] && (rcw == 3'b000);
    cmd_ref  = !sd_cmd[3] && (rcw == 3'b001);
    // ACTIVE, READ, WRITE, BURST_TERM
    cmd_data = !sd_cmd[3] && ((rcw == 3'b011) || (rcw == 3'b101) ||
                              (rcw == 3'b100) || (rcw == 3'b110));
  end

  // Error detection; spacing violations take priority over ordering ones.
  logic [2:0] order_code;
  logic       spc_err;
  logic [2:0] err_code_d;
  logic       err_hit;

  always_comb begin
    order_code = 3'd0;
    unique case (state_q)
      StWaitPre: begin
        if (cmd_pre && !sd_a[10]) begin
          order_code = 3'd2;
        end else if (!cmd_idle && !cmd_pre) begin
          order_code = 3'd1;
        end
      end
      StWaitLmr: begin
        if (cmd_data) begin
          order_code = 3'd1;
        end
      end
`ifdef SDRAM_MON_DOUBLE_LMR_EN
      StWaitLmr2: begin
        if (cmd_lmr) begin
          if (sd_a != mode_reg_q) begin
            order_code = 3'd5;
          end
        end else if (!cmd_idle && !cmd_ref) begin
          order_code = 3'd1;
        end
      end
`endif
      default: ;
    endcase
    spc_err    = !cmd_idle && (spc_q != '0);
    err_code_d = spc_err ? (last_lmr_q ? 3'd4 : 3'd3) : order_code;
    err_hit    = (state_q != StError) && (err_code_d != 3'd0);
  end

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state_q      <= StWaitPre;
      spc_q        <= '0;
      last_lmr_q   <= 1'b0;
      init_done_q  <= 1'b0;
      mode_reg_q   <= '0;
      mode_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 3'd0;
      lmr_count_q  <= 4'd0;
    end else if (state_q != StError) begin
      // The LOAD_MODE that triggers an error is still counted.
      if (cmd_lmr && (lmr_count_q != 4'hf)) begin
        lmr_count_q <= lmr_count_q + 4'd1;
      end

      if (cmd_pre) begin
        spc_q      <= TrpLoad;
        last_lmr_q <= 1'b0;
      end else if (cmd_lmr) begin
        spc_q      <= TmrdLoad;
        last_lmr_q <= 1'b1;
      end else if (spc_q != '0) begin
        spc_q <= spc_q - SpcW'(1);
      end

      if (err_hit) begin
        // init_done drops on error and then stays frozen at 0 in StError.
        state_q     <= StError;
        err_q       <= 1'b1;
        err_code_q  <= err_code_d;
        init_done_q <= 1'b0;
      end else begin
        unique case (state_q)
          StWaitPre: begin
            // Single-bank precharge was rejected above, so this is PRECHARGE-all.
            if (cmd_pre) begin
              state_q <= StWaitLmr;
            end
          end
          StWaitLmr: begin
            if (cmd_lmr) begin
              mode_reg_q   <= sd_a;
              mode_valid_q <= 1'b1;
`ifdef SDRAM_MON_DOUBLE_LMR_EN
              state_q      <= StWaitLmr2;
`else
              state_q      <= StReady;
              init_done_q  <= 1'b1;
`endif
            end
          end
`ifdef SDRAM_MON_DOUBLE_LMR_EN
          StWaitLmr2: begin
            // A mismatching value was rejected above, so mode_reg already matches.
            if (cmd_lmr) begin
              state_q     <= StReady;
              init_done_q <= 1'b1;
            end
          end
`endif
          StReady: begin
            if (cmd_lmr) begin
              mode_reg_q <= sd_a;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign init_done  = init_done_q;
  assign mode_reg   = mode_reg_q;
  assign mode_valid = mode_valid_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign lmr_count  = lmr_count_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Scoreboard bench for sdram_init_monitor (T_RP=3, T_MRD=2). Stimulus pushes
// the expected output set for a command; a monitor pops and compares one
// entry just after each rising edge. Expectations follow the build's
// SDRAM_MON_DOUBLE_LMR_EN setting.

module tb_sdram_init_monitor;

`ifdef SDRAM_MON_DOUBLE_LMR_EN
  localparam bit Dbl = 1'b1;
`else
  localparam bit Dbl = 1'b0;
`endif

  localparam logic [3:0] CInh = 4'b1000;
  localparam logic [3:0] CAct = 4'b0011;
  localparam logic [3:0] CPre = 4'b0010;
  localparam logic [3:0] CRef = 4'b0001;
  localparam logic [3:0] CLmr = 4'b0000;

  logic        sd_clk;
  logic        reset;
  logic [3:0]  sd_cmd;
  logic [12:0] sd_a;
  logic        init_done;
  logic [12:0] mode_reg;
  logic        mode_valid;
  logic        err;
  logic [2:0]  err_code;
  logic [3:0]  lmr_count;

  sdram_init_monitor #(
    .T_RP  (3),
    .T_MRD (2)
  ) dut (
    .sd_clk     (sd_clk),
    .reset      (reset),
    .sd_cmd     (sd_cmd),
    .sd_a       (sd_a),
    .init_done  (init_done),
    .mode_reg   (mode_reg),
    .mode_valid (mode_valid),
    .err        (err),
    .err_code   (err_code),
    .lmr_count  (lmr_count)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  typedef struct {
    string       name;
    logic        done;
    logic [12:0] mode;
    logic        mv;
    logic        e;
    logic [2:0]  code;
    logic [3:0]  cnt;
    logic        ign_done;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Monitor: every output is registered, so sample 1 time unit after the edge.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge sd_clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = (e.ign_done || (init_done === e.done)) && (mode_reg === e.mode) &&
             (mode_valid === e.mv) && (err === e.e) && (err_code === e.code) &&
             (lmr_count === e.cnt);
        n_total++;
        if (ok) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got done=%0b mode=%h mv=%0b err=%0b code=%0d cnt=%0d, want done=%0b%s mode=%h mv=%0b err=%0b code=%0d cnt=%0d",
                   e.name, init_done, mode_reg, mode_valid, err, err_code, lmr_count,
                   e.done, e.ign_done ? "(any)" : "", e.mode, e.mv, e.e, e.code, e.cnt);
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic [3:0] cmd, input logic [12:0] a);
    @(negedge sd_clk);
    reset  = rst;
    sd_cmd = cmd;
    sd_a   = a;
  endtask

  task automatic push_exp(input string name, input logic done, input logic [12:0] mode,
                          input logic mv, input logic e, input logic [2:0] code,
                          input logic [3:0] cnt, input logic ign_done);
    exp_t x;
    x.name = name; x.done = done; x.mode = mode; x.mv = mv;
    x.e = e; x.code = code; x.cnt = cnt; x.ign_done = ign_done;
    exp_q.push_back(x);
  endtask

  // The ACTIVE presented during reset must be ignored.
  task automatic do_reset(input string name);
    drive(1'b1, CAct, 13'h1fff);
    push_exp(name, 1'b0, 13'h0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, CInh, 13'h0);
  endtask

  initial begin
    reset  = 1'b1;
    sd_cmd = CInh;
    sd_a   = 13'h0;
    do_reset("reset");

    // Early command, then ERROR ignores everything
    drive(1'b0, CAct, 13'h0);
    push_exp("early_cmd", 0, 13'h0, 0, 1, 3'd1, 4'd0, 0);
    drive(1'b0, CPre, 13'h0400);
    push_exp("err_sticky_pre", 0, 13'h0, 0, 1, 3'd1, 4'd0, 0);
    drive(1'b0, CLmr, 13'h0022);
    push_exp("err_sticky_lmr", 0, 13'h0, 0, 1, 3'd1, 4'd0, 0);
    do_reset("reset_from_err");

    // Single-bank precharge in WAIT_PRE
    drive(1'b0, CPre, 13'h0000);
    push_exp("single_bank_pre", 0, 13'h0, 0, 1, 3'd2, 4'd0, 0);
    do_reset("reset2");

    // tRP violation: LOAD_MODE at n+2
    drive(1'b0, CPre, 13'h0400);
    push_exp("pre_all", 0, 13'h0, 0, 0, 3'd0, 4'd0, 0);
    idle(1);
    drive(1'b0, CLmr, 13'h0022);
    push_exp("trp_violation", 0, 13'h0, 0, 1, 3'd3, 4'd1, 0);
    do_reset("reset3");

    // tRP boundary legal at n+3, then tMRD violation at m+1
    drive(1'b0, CPre, 13'h0400);
    idle(2);
    drive(1'b0, CLmr, 13'h0022);
    push_exp("trp_boundary_lmr", !Dbl, 13'h0022, 1, 0, 3'd0, 4'd1, 0);
    drive(1'b0, CRef, 13'h0);
    push_exp("tmrd_violation", 0, 13'h0022, 1, 1, 3'd4, 4'd1, 1);
    do_reset("reset4");

    // tMRD boundary at m+2 and second LOAD_MODE with a different value
    drive(1'b0, CPre, 13'h0400);
    idle(2);
    drive(1'b0, CLmr, 13'h0022);
    idle(1);
    drive(1'b0, CLmr, 13'h0023);
    if (Dbl) push_exp("lmr2_mismatch", 0, 13'h0022, 1, 1, 3'd5, 4'd2, 0);
    else     push_exp("lmr2_update", 1, 13'h0023, 1, 0, 3'd0, 4'd2, 0);
    idle(2);
    drive(1'b0, CAct, 13'h0);
    if (Dbl) push_exp("mismatch_sticky", 0, 13'h0022, 1, 1, 3'd5, 4'd2, 0);
    else     push_exp("ready_any_cmd", 1, 13'h0023, 1, 0, 3'd0, 4'd2, 0);
    do_reset("reset5");

    // WAIT_LMR: PRECHARGE-all and AUTO_REFRESH legal, ACTIVE is err 1
    drive(1'b0, CPre, 13'h0400);
    idle(2);
    drive(1'b0, CRef, 13'h0);
    push_exp("wait_lmr_ref", 0, 13'h0, 0, 0, 3'd0, 4'd0, 0);
    idle(1);
    drive(1'b0, CPre, 13'h0400);
    push_exp("wait_lmr_pre", 0, 13'h0, 0, 0, 3'd0, 4'd0, 0);
    idle(2);
    drive(1'b0, CAct, 13'h0);
    push_exp("wait_lmr_act", 0, 13'h0, 0, 1, 3'd1, 4'd0, 0);
    do_reset("reset6");

    // Spacing beats ordering: ACTIVE right after PRECHARGE
    drive(1'b0, CPre, 13'h0400);
    drive(1'b0, CAct, 13'h0);
    push_exp("priority_spacing", 0, 13'h0, 0, 1, 3'd3, 4'd0, 0);
    do_reset("reset7");

    // Nominal sequence
    drive(1'b0, CPre, 13'h0400);
    idle(175);
    drive(1'b0, CLmr, 13'h0022);
    push_exp("nominal_lmr1", !Dbl, 13'h0022, 1, 0, 3'd0, 4'd1, 0);
    idle(15);
    drive(1'b0, CLmr, 13'h0022);
    push_exp("nominal_lmr2", 1, 13'h0022, 1, 0, 3'd0, 4'd2, 0);
    drive(1'b0, CInh, 13'h0);
    push_exp("nominal_hold", 1, 13'h0022, 1, 0, 3'd0, 4'd2, 0);
    do_reset("reset8");

    // lmr_count saturation
    drive(1'b0, CPre, 13'h0400);
    idle(2);
    drive(1'b0, CLmr, 13'h0030);
    for (int i = 0; i < 14; i++) begin
      idle(1);
      drive(1'b0, CLmr, 13'h0030);
    end
    push_exp("lmr_count_15", 1, 13'h0030, 1, 0, 3'd0, 4'd15, 0);
    idle(1);
    drive(1'b0, CLmr, 13'h0030);
    push_exp("lmr_count_sat", 1, 13'h0030, 1, 0, 3'd0, 4'd15, 0);

    drive(1'b0, CInh, 13'h0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sd_clk);
    #2;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
